// File: rtl/muladd_pipe_if.sv
// muladd_pipe_if: operand/result bundle for the muladd_pipe block.
//   i_a, i_b, i_c : operands (DW bits)
//   i_op          : 0 = a+b*c, 1 = a-b*c, 2 = b*c, 3 = a
//   i_htId        : thread tag travelling with the operation
//   i_vld / o_rdy : issue handshake (accept on i_vld & o_rdy)
//   o_res, o_htId : result and its tag, both zero while o_vld = 0
//   o_vld / i_rdy : result handshake (pop on o_vld & i_rdy)
// The slave modport is the block's view; master is the producer/consumer view.
interface muladd_pipe_if #(
  parameter int DW     = 64,
  parameter int HTID_W = 7
);
  logic [DW-1:0]     i_a;
  logic [DW-1:0]     i_b;
  logic [DW-1:0]     i_c;
  logic [1:0]        i_op;
  logic [HTID_W-1:0] i_htId;
  logic              i_vld;
  logic              o_rdy;
  logic [DW-1:0]     o_res;
  logic [HTID_W-1:0] o_htId;
  logic              o_vld;
  logic              i_rdy;

  modport slave (
    input  i_a, i_b, i_c, i_op, i_htId, i_vld, i_rdy,
    output o_rdy, o_res, o_htId, o_vld
  );

  modport master (
    output i_a, i_b, i_c, i_op, i_htId, i_vld, i_rdy,
    input  o_rdy, o_res, o_htId, o_vld
  );
endinterface

// File: rtl/muladd_pipe.sv
// muladd_pipe: fixed-latency multiply-accumulate pipeline with a result FIFO
// and credit-based admission.
//   ck      : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : muladd_pipe_if.slave (operands, op, tag, both handshakes)
// An op accepted at edge k passes MUL_LAT multiplier stages, one add stage,
// and is written into the FIFO at edge k+MUL_LAT+1. The credit counter counts
// ops in flight plus FIFO entries, so admission stops before the FIFO could
// ever be asked to hold more than FIFO_DEPTH results.
module muladd_pipe #(
  parameter int DW         = 64,
  parameter int HTID_W     = 7,
  parameter int MUL_LAT    = 18,
  parameter int FIFO_DEPTH = 32
) (
  input logic          ck,
  input logic          i_rst_n,
  muladd_pipe_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [DW-1:0]     p;
    logic [DW-1:0]     a;
    logic [1:0]        op;
    logic [HTID_W-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic [HTID_W-1:0] tag;
    logic [DW-1:0]     res;
  } entry_t;

  // Pipeline state: data stages carry no reset, only the valid bits do.
  stage_t            stage_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;
  logic              add_vld_q;
  logic [DW-1:0]     add_res_q;
  logic [HTID_W-1:0] add_tag_q;
  logic [DW-1:0]     add_res;

  // Result FIFO and credit counter. Pointers carry one extra wrap bit so that
  // equal pointers mean empty.
  entry_t            mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  entry_t            rd_entry;

  logic rdy;
  logic vld;
  logic accept;
  logic pop;

  assign rdy    = (cnt_q < DEPTH_C);
  assign vld    = (wr_ptr_q != rd_ptr_q);
  assign accept = bus.i_vld & rdy;
  assign pop    = vld & bus.i_rdy;

  // Multiplier and matched delay line; the product is formed at stage 0 and
  // simply carried through the remaining stages.
  always_ff @(posedge ck) begin
    stage_q[0].p   <= bus.i_b * bus.i_c;
    stage_q[0].a   <= bus.i_a;
    stage_q[0].op  <= bus.i_op;
    stage_q[0].tag <= bus.i_htId;
    for (int i = 1; i < MUL_LAT; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  always_ff @(posedge ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q     <= '0;
      add_vld_q <= 1'b0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      add_vld_q <= vld_q[MUL_LAT-1];
    end
  end

  always_comb begin
    add_res = stage_q[MUL_LAT-1].a;
    case (stage_q[MUL_LAT-1].op)
      2'd0:    add_res = stage_q[MUL_LAT-1].a + stage_q[MUL_LAT-1].p;
      2'd1:    add_res = stage_q[MUL_LAT-1].a - stage_q[MUL_LAT-1].p;
      2'd2:    add_res = stage_q[MUL_LAT-1].p;
      default: add_res = stage_q[MUL_LAT-1].a;
    endcase
  end

  always_ff @(posedge ck) begin
    add_res_q <= add_res;
    add_tag_q <= stage_q[MUL_LAT-1].tag;
  end

  // FIFO storage; a write always finds room because of the credit counter.
  always_ff @(posedge ck) begin
    if (add_vld_q) begin
      mem[wr_ptr_q[AW-1:0]] <= '{tag: add_tag_q, res: add_res_q};
    end
  end

  always_ff @(posedge ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (add_vld_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // First-word-fall-through read: the head entry is presented directly.
  assign rd_entry   = mem[rd_ptr_q[AW-1:0]];
  assign bus.o_rdy  = rdy;
  assign bus.o_vld  = vld;
  assign bus.o_res  = vld ? rd_entry.res : '0;
  assign bus.o_htId = vld ? rd_entry.tag : '0;
endmodule

// File: tb/tb_muladd_pipe.sv
// tb_muladd_pipe: directed bench for muladd_pipe with a default-parameter
// instance and a small instance (DW=32, MUL_LAT=4, FIFO_DEPTH=8).
module tb_muladd_pipe;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  muladd_pipe_if #(.DW(64), .HTID_W(7)) bus ();
  muladd_pipe_if #(.DW(32), .HTID_W(7)) sbus ();

  muladd_pipe #(.DW(64), .HTID_W(7), .MUL_LAT(18), .FIFO_DEPTH(32)) dut (
    .ck(ck), .i_rst_n(rst_n), .bus(bus)
  );
  muladd_pipe #(.DW(32), .HTID_W(7), .MUL_LAT(4), .FIFO_DEPTH(8)) sdut (
    .ck(ck), .i_rst_n(rst_n), .bus(sbus)
  );

  typedef struct {
    logic [63:0] res;
    logic [6:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n, acc, got, issued, gaps, rdy_low, vld_seen;
  bit          started;
  logic [63:0] held;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic [1:0] op);
    logic [63:0] p;
    p = b * c;
    case (op)
      2'd0:    return a + p;
      2'd1:    return a - p;
      2'd2:    return p;
      default: return a;
    endcase
  endfunction

  task automatic drive_rand(input logic [6:0] tag);
    bus.i_a    = {$urandom, $urandom};
    bus.i_b    = {$urandom, $urandom};
    bus.i_c    = {$urandom, $urandom};
    bus.i_op   = 2'($urandom_range(0, 3));
    bus.i_htId = tag;
  endtask

  task automatic push_cur();
    exp_t e;
    e.res = ref_model(bus.i_a, bus.i_b, bus.i_c, bus.i_op);
    e.tag = bus.i_htId;
    q.push_back(e);
  endtask

  task automatic check_front(input string nm);
    exp_t e;
    chk({nm, " model nonempty"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({nm, " res"}, bus.o_res, e.res);
      chk({nm, " tag"}, 64'(bus.o_htId), 64'(e.tag));
    end
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [1:0] op, input logic [6:0] tag,
                        input logic [63:0] exp);
    int k;
    bus.i_a = a; bus.i_b = b; bus.i_c = c; bus.i_op = op; bus.i_htId = tag;
    bus.i_vld = 1'b1;
    bus.i_rdy = 1'b1;
    chk({nm, " o_rdy"}, 64'(bus.o_rdy), 64'd1);
    step();
    bus.i_vld = 1'b0;
    k = 0;
    while (!bus.o_vld && k < 40) begin
      step();
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'd19);
    chk({nm, " res"}, bus.o_res, exp);
    chk({nm, " tag"}, 64'(bus.o_htId), 64'(tag));
    step();
    chk({nm, " o_vld after pop"}, 64'(bus.o_vld), 64'd0);
    chk({nm, " o_res zeroed"}, bus.o_res, 64'd0);
  endtask

  initial begin
    bus.i_a = '0; bus.i_b = '0; bus.i_c = '0; bus.i_op = '0; bus.i_htId = '0;
    bus.i_vld = 1'b0; bus.i_rdy = 1'b1;
    sbus.i_a = '0; sbus.i_b = '0; sbus.i_c = '0; sbus.i_op = '0; sbus.i_htId = '0;
    sbus.i_vld = 1'b0; sbus.i_rdy = 1'b1;

    // Reset state
    step(); step();
    chk("reset o_vld", 64'(bus.o_vld), 64'd0);
    chk("reset o_rdy", 64'(bus.o_rdy), 64'd1);
    chk("reset o_res", bus.o_res, 64'd0);
    chk("reset o_htId", 64'(bus.o_htId), 64'd0);
    chk("small reset o_vld", 64'(sbus.o_vld), 64'd0);
    chk("small reset o_rdy", 64'(sbus.o_rdy), 64'd1);
    rst_n = 1'b1;
    step();
    chk("release o_rdy", 64'(bus.o_rdy), 64'd1);

    // Single ops
    run_op("op0", 64'd10, 64'd3, 64'd4, 2'd0, 7'd5, 64'd22);
    run_op("op1", 64'd10, 64'd3, 64'd4, 2'd1, 7'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("op2", 64'd10, 64'd3, 64'd4, 2'd2, 7'd5, 64'd12);
    run_op("op3", 64'd10, 64'd3, 64'd4, 2'd3, 7'd5, 64'd10);
    run_op("wrap op0", '1, '1, '1, 2'd0, 7'd9, 64'd0);
    run_op("wrap op2", '1, '1, '1, 2'd2, 7'd9, 64'd1);
    run_op("wrap op1", '1, '1, '1, 2'd1, 7'd9, 64'hFFFF_FFFF_FFFF_FFFE);

    // Streaming: 200 back-to-back ops
    issued = 0; got = 0; gaps = 0; rdy_low = 0; started = 0;
    bus.i_rdy = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 200; cyc++) begin
      if (bus.o_vld) begin
        started = 1;
        check_front("stream");
        got++;
      end else if (started) begin
        gaps++;
      end
      if (issued < 200) begin
        if (!bus.o_rdy) rdy_low++;
        drive_rand(7'(issued % 128));
        bus.i_vld = 1'b1;
        if (bus.o_rdy) begin
          push_cur();
          issued++;
        end
      end else begin
        bus.i_vld = 1'b0;
      end
      step();
    end
    bus.i_vld = 1'b0;
    chk("stream count", 64'(got), 64'd200);
    chk("stream gaps", 64'(gaps), 64'd0);
    chk("stream o_rdy low", 64'(rdy_low), 64'd0);

    // Backpressure: consumer stalled, producer always offering
    bus.i_rdy = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      drive_rand(7'(acc));
      bus.i_vld = 1'b1;
      if (bus.o_rdy) begin
        push_cur();
        acc++;
      end
      step();
    end
    bus.i_vld = 1'b0;
    chk("bp accepts", 64'(acc), 64'd32);
    chk("bp o_rdy low", 64'(bus.o_rdy), 64'd0);
    chk("bp o_vld", 64'(bus.o_vld), 64'd1);
    held = bus.o_res;
    step();
    chk("bp hold o_vld", 64'(bus.o_vld), 64'd1);
    chk("bp hold o_res", bus.o_res, held);
    bus.i_rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 1) chk("bp o_rdy after pop", 64'(bus.o_rdy), 64'd1);
      if (bus.o_vld) begin
        check_front("bp drain");
        got++;
      end
      step();
    end
    chk("bp drain count", 64'(got), 64'd32);
    chk("bp model empty", 64'(q.size()), 64'd0);

    // Random i_vld / i_rdy toggling
    issued = 0; got = 0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      bus.i_rdy = (cyc >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_rand(7'(issued));
      bus.i_vld = (cyc < 150) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.o_vld && bus.i_rdy) begin
        check_front("toggle");
        got++;
      end
      if (bus.i_vld && bus.o_rdy) begin
        push_cur();
        issued++;
      end
      step();
    end
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b1;
    chk("toggle count", 64'(got), 64'(issued));
    chk("toggle model empty", 64'(q.size()), 64'd0);

    // Reset mid-flight: 5 results in the FIFO, 10 ops still in the pipeline
    bus.i_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive_rand(7'(i));
      bus.i_vld = 1'b1;
      step();
    end
    bus.i_vld = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("pre-reset o_vld", 64'(bus.o_vld), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("in reset o_vld", 64'(bus.o_vld), 64'd0);
    chk("in reset o_rdy", 64'(bus.o_rdy), 64'd1);
    step(); step();
    rst_n = 1'b1;
    bus.i_rdy = 1'b1;
    step();
    chk("post-reset o_rdy", 64'(bus.o_rdy), 64'd1);
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_vld) vld_seen++;
      step();
    end
    chk("post-reset stale results", 64'(vld_seen), 64'd0);
    run_op("post-reset op", 64'd1, 64'd2, 64'd3, 2'd0, 7'd1, 64'd7);

    // Small instance: latency, wrap, backpressure at depth 8
    sbus.i_a = '0; sbus.i_b = 32'hFFFF_FFFF; sbus.i_c = 32'd2; sbus.i_op = 2'd2;
    sbus.i_htId = 7'd3; sbus.i_vld = 1'b1; sbus.i_rdy = 1'b1;
    step();
    sbus.i_vld = 1'b0;
    n = 0;
    while (!sbus.o_vld && n < 20) begin
      step();
      n++;
    end
    chk("small latency", 64'(n), 64'd5);
    chk("small res", 64'(sbus.o_res), 64'hFFFF_FFFE);
    chk("small tag", 64'(sbus.o_htId), 64'd3);
    step();
    sbus.i_rdy = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      sbus.i_a = 32'(cyc); sbus.i_op = 2'd3; sbus.i_htId = 7'(acc);
      sbus.i_vld = 1'b1;
      if (sbus.o_rdy) acc++;
      step();
    end
    sbus.i_vld = 1'b0;
    chk("small accepts", 64'(acc), 64'd8);
    chk("small o_rdy low", 64'(sbus.o_rdy), 64'd0);
    sbus.i_rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sbus.o_vld) begin
        chk("small drain tag", 64'(sbus.o_htId), 64'(got));
        got++;
      end
      step();
    end
    chk("small drain count", 64'(got), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
